pc_sequencer: RTL and testbench

- Fetch-side controller that owns the program counter register and sequences instruction fetches.
- Each cycle it selects the next PC from: sequential (+STEP), redirect (branch/jump target), trap vector, or hold (stall).
- It drives a req/ack handshake toward instruction memory and reports each completed fetch to decode with a one-cycle valid pulse.

---
 rtl/pc_sequencer.sv | 70 +++++++
 tb/tb_pc_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetches over a req/ack handshake
// Ports:
//    clk, rst            clock (rising edge), asynchronous active-high reset
//    stall               decode back-pressure; stops new fetches once any outstanding one completes
//    redirect_valid      branch/jump taken; redirect_target is the new PC
//    trap                exception request, highest priority
//    imem_req/imem_addr  fetch request and its address (the pc register)
//    imem_ack            memory completes the fetch this cycle
//    pc_out/pc_valid     address of the last completed fetch, one-cycle completion pulse
//    misaligned          one-cycle pulse for a redirect target that is not STEP-aligned
module pc_sequencer #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int               STEP         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             trap,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   output logic [WIDTH-1:0] pc_out,
   output logic             pc_valid,
   output logic             misaligned
);
   typedef enum logic [1:0] {BOOT, REQ, STALL, FLUSH} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_pc, r_pc_out;
   logic             r_valid, r_mis;
   logic             w_active, w_align, w_trap, w_redir, w_xfer;
   assign w_align  = (redirect_target & WIDTH'(STEP - 1)) == '0;
   // BOOT ignores trap/redirect; every other state honours them
   assign w_active = r_state != BOOT;
   // a misaligned redirect is routed to the trap vector like a trap
   assign w_trap   = w_active & (trap | (redirect_valid & ~w_align));
   assign w_redir  = w_active & ~w_trap & redirect_valid;
   // trap/redirect discard a same-cycle ack
   assign w_xfer   = (r_state == REQ) & imem_ack & ~w_trap & ~w_redir;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= BOOT;
      else     r_state <= w_next;
   // an unacknowledged request is held regardless of stall, so the address never moves under req
   always_comb
      w_next = (w_trap | w_redir)                ? FLUSH :
               ((r_state == REQ) & ~imem_ack)    ? REQ   :
               stall                             ? STALL : REQ;
   always_comb begin
      imem_req  = r_state == REQ;
      imem_addr = r_pc;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_pc     <= RESET_VECTOR;
         r_pc_out <= '0;
         r_valid  <= 1'b0;
         r_mis    <= 1'b0;
      end else begin
         r_pc     <= w_trap ? TRAP_VECTOR : w_redir ? redirect_target : w_xfer ? r_pc + WIDTH'(STEP) : r_pc;
         r_pc_out <= w_xfer ? r_pc : r_pc_out;
         r_valid  <= w_xfer;
         r_mis    <= w_active & ~trap & redirect_valid & ~w_align;
      end
   assign pc_out     = r_pc_out;
   assign pc_valid   = r_valid;
   assign misaligned = r_mis;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
   localparam logic [31:0] RV = 32'h0, TV = 32'h100;
   localparam int          STEP = 4;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0, trap = 1'b0, imem_ack = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        imem_req, pc_valid, misaligned;
   logic [31:0] imem_addr, pc_out;
   int          n_cmp = 0, n_bad = 0;
   // model: fetch address, whether a request is showing, first cycle after reset, and last pulses
   logic [31:0] m_pc, m_pc_out;
   bit          m_req, m_boot, m_valid, m_mis;
   pc_sequencer #(.WIDTH(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .STEP(STEP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .trap(trap), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .pc_out(pc_out), .pc_valid(pc_valid), .misaligned(misaligned));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_pc = RV; m_pc_out = '0; m_req = 0; m_boot = 1; m_valid = 0; m_mis = 0;
   endtask
   task automatic chk_all();
      chk("req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("addr", imem_addr, m_pc);
      chk("pc_valid", 32'(pc_valid), 32'(m_valid));
      chk("pc_out", pc_out, m_pc_out);
      chk("misaligned", 32'(misaligned), 32'(m_mis));
   endtask
   // one clock with the given inputs; the model applies the priority rules, then all outputs are checked
   task automatic step(input bit s, input bit rv, input logic [31:0] t, input bit tr, input bit ak);
      bit bad;
      stall = s; redirect_valid = rv; redirect_target = t; trap = tr; imem_ack = ak;
      @(posedge clk);
      bad = rv && (t % STEP != 0);
      m_valid = 0; m_mis = 0;
      if (m_boot) begin
         m_boot = 0; m_req = !s;
      end else if (tr || bad) begin
         m_pc = TV; m_mis = !tr && bad; m_req = 0;
      end else if (rv) begin
         m_pc = t; m_req = 0;
      end else if (m_req && ak) begin
         m_valid = 1; m_pc_out = m_pc; m_pc = 32'((64'(m_pc) + STEP) % 64'h1_0000_0000); m_req = !s;
      end else if (!m_req) m_req = !s;
      #1 chk_all();
   endtask
   // asserted between edges: request must drop at once, before any clock
   task automatic async_reset();
      #2 rst = 1'b1;
      #1 chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", imem_addr, RV);
      chk("rst_valid", 32'(pc_valid), 32'h0);
      model_reset();
      rst = 1'b0;
   endtask
   initial begin
      model_reset();
      @(posedge clk);
      #1 chk("reset_req", 32'(imem_req), 32'h0);
      chk("reset_pc_out", pc_out, 32'h0);
      chk("reset_addr", imem_addr, RV);
      rst = 1'b0;
      step(0, 0, 0, 0, 0);
      chk("boot_addr", imem_addr, 32'h0);
      step(0, 0, 0, 0, 1);
      chk("seq_addr4", imem_addr, 32'h4);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("held_addr8", imem_addr, 32'h8);
      step(1, 0, 0, 0, 1);
      chk("stall_req0", 32'(imem_req), 32'h0);
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("release_addrC", imem_addr, 32'hC);
      step(0, 0, 0, 0, 1);
      step(0, 1, 32'h40, 0, 1);
      chk("redir_no_valid", 32'(pc_valid), 32'h0);
      step(0, 0, 0, 0, 0);
      chk("redir_addr40", imem_addr, 32'h40);
      step(0, 1, 32'h42, 0, 0);
      chk("mis_pulse", 32'(misaligned), 32'h1);
      step(0, 0, 0, 0, 0);
      chk("mis_addr100", imem_addr, 32'h100);
      step(0, 1, 32'h80, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("trap_addr100", imem_addr, 32'h100);
      step(0, 1, 32'hFFFF_FFFC, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("wrap_addr0", imem_addr, 32'h0);
      step(0, 0, 0, 0, 0);
      async_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(99) == 0) async_reset();
         else step($urandom_range(9) < 3, $urandom_range(9) == 0,
                   ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                   $urandom_range(19) == 0, $urandom_range(9) < 6);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
